// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Bus-mapped scan controller for an 8-digit, active-low 7-segment display.
//   Holds a DATA register (one hex nibble per digit) and a CTRL register
//   (blank mask, DP mask, enable). Digit selects are time-multiplexed with a
//   programmable slot time and an anti-ghosting dead time. All display outputs
//   are registered.
//
// Parameters
//   SCAN_DIV   clk cycles per digit slot (ON + DEAD), >= 2
//   DEAD_CYC   cycles per slot with all digits off, 0 <= DEAD_CYC < SCAN_DIV
//   ADDR_BASE  addr[11:0] of DATA; CTRL sits at ADDR_BASE + 4
//
// Ports
//   clk         clock
//   rst         asynchronous active-high reset
//   addr[31:0]  bus address (only [11:0] decoded)
//   wen         single-cycle write strobe
//   wdata[31:0] write data
//   rdata[31:0] combinational readback (DATA, CTRL, else 0)
//   dig_en[7:0] digit selects, active-low, at most one bit low
//   seg[7:0]    {A,B,C,D,E,F,G,DP}, active-low
//   frame_done  one-cycle pulse when the digit-7 slot ends
module seg_scan_ctrl #(
  parameter int          SCAN_DIV  = 50000,
  parameter int          DEAD_CYC  = 64,
  parameter logic [11:0] ADDR_BASE = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int          CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] ON_LAST   = CW'(SCAN_DIV - DEAD_CYC - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYC > 0) ? (DEAD_CYC - 1) : 0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [11:0] ADDR_CTRL = ADDR_BASE + 12'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  // Hex digit to active-low {A..G,DP} pattern, DP off.
  function automatic logic [7:0] hex7(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0:    pat = 8'h03;
      4'h1:    pat = 8'h9F;
      4'h2:    pat = 8'h25;
      4'h3:    pat = 8'h0D;
      4'h4:    pat = 8'h99;
      4'h5:    pat = 8'h49;
      4'h6:    pat = 8'h41;
      4'h7:    pat = 8'h1F;
      4'h8:    pat = 8'h01;
      4'h9:    pat = 8'h09;
      4'hA:    pat = 8'h11;
      4'hB:    pat = 8'hC1;
      4'hC:    pat = 8'h63;
      4'hD:    pat = 8'h85;
      4'hE:    pat = 8'h61;
      4'hF:    pat = 8'h71;
      default: pat = 8'hFF;
    endcase
    return pat;
  endfunction

  // Digit select for a slot entry; a blanked digit keeps every select off.
  function automatic logic [7:0] entry_dig(input logic [2:0] idx, input logic [7:0] blank);
    logic [7:0] one_hot;
    one_hot = 8'd1 << idx;
    if (blank[idx]) begin
      return 8'hFF;
    end else begin
      return ~one_hot;
    end
  endfunction

  // Segment pattern for a slot entry, with DP lit when its mask bit is set.
  function automatic logic [7:0] entry_seg(input logic [2:0] idx, input logic [31:0] data,
                                           input logic [7:0] dp);
    logic [3:0] nib;
    nib = data[{idx, 2'b00} +: 4];
    return hex7(nib) & {7'h7F, ~dp[idx]};
  endfunction

  logic [31:0]   r_data;
  logic [16:0]   r_ctrl;
  state_t        r_state;
  logic [2:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_dig_en;
  logic [7:0]    r_seg;
  logic          r_frame_done;

  state_t        w_state_nxt;
  logic [2:0]    w_idx_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [7:0]    w_dig_nxt;
  logic [7:0]    w_seg_nxt;
  logic          w_fd_nxt;

  logic          w_dec_data;
  logic          w_dec_ctrl;
  logic          w_enable;
  logic [2:0]    w_idx_inc;
  logic [7:0]    w_blank;
  logic [7:0]    w_dp;
  logic          w_unused_addr;

  assign w_dec_data    = (addr[11:0] == ADDR_BASE);
  assign w_dec_ctrl    = (addr[11:0] == ADDR_CTRL);
  assign w_enable      = r_ctrl[16];
  assign w_blank       = r_ctrl[7:0];
  assign w_dp          = r_ctrl[15:8];
  assign w_idx_inc     = r_idx + 3'd1;
  assign w_unused_addr = ^addr[31:12];

  // Bus register writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= 32'h0000_0000;
      r_ctrl <= 17'h1_0000;
    end else if (wen) begin
      if (w_dec_data) begin
        r_data <= wdata;
      end else if (w_dec_ctrl) begin
        r_ctrl <= wdata[16:0];
      end else begin
        r_data <= r_data;
      end
    end else begin
      r_data <= r_data;
    end
  end

  // Combinational readback mux.
  always_comb begin
    rdata = 32'h0000_0000;
    if (w_dec_data) begin
      rdata = r_data;
    end else if (w_dec_ctrl) begin
      rdata = {15'h0000, r_ctrl};
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  // Scan state, slot counter and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= 3'd0;
      r_cnt        <= '0;
      r_dig_en     <= 8'hFF;
      r_seg        <= 8'hFF;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dig_en     <= w_dig_nxt;
      r_seg        <= w_seg_nxt;
      r_frame_done <= w_fd_nxt;
    end
  end

  // Next-state logic. Outputs for a new slot are loaded on the entry edge
  // from the current register contents so the whole slot shows one frozen
  // pattern. Disable has priority over slot completion and never pulses
  // frame_done.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + CNT_ONE;
    w_dig_nxt   = r_dig_en;
    w_seg_nxt   = r_seg;
    w_fd_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_idx_nxt = 3'd0;
        w_cnt_nxt = '0;
        if (w_enable) begin
          w_state_nxt = ST_ON;
          w_dig_nxt   = entry_dig(3'd0, w_blank);
          w_seg_nxt   = entry_seg(3'd0, r_data, w_dp);
        end else begin
          w_state_nxt = ST_IDLE;
          w_dig_nxt   = 8'hFF;
          w_seg_nxt   = 8'hFF;
        end
      end
      ST_ON: begin
        if (!w_enable) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = 3'd0;
          w_cnt_nxt   = '0;
          w_dig_nxt   = 8'hFF;
          w_seg_nxt   = 8'hFF;
        end else if (r_cnt == ON_LAST) begin
          w_cnt_nxt = '0;
          if (DEAD_CYC == 0) begin
            // No dead time: the slot ends here and the next digit starts.
            w_state_nxt = ST_ON;
            w_idx_nxt   = w_idx_inc;
            w_dig_nxt   = entry_dig(w_idx_inc, w_blank);
            w_seg_nxt   = entry_seg(w_idx_inc, r_data, w_dp);
            w_fd_nxt    = (r_idx == 3'd7);
          end else begin
            w_state_nxt = ST_DEAD;
            w_dig_nxt   = 8'hFF;
          end
        end else begin
          w_state_nxt = ST_ON;
        end
      end
      ST_DEAD: begin
        if (!w_enable) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = 3'd0;
          w_cnt_nxt   = '0;
          w_dig_nxt   = 8'hFF;
          w_seg_nxt   = 8'hFF;
        end else if (r_cnt == DEAD_LAST) begin
          w_state_nxt = ST_ON;
          w_idx_nxt   = w_idx_inc;
          w_cnt_nxt   = '0;
          w_dig_nxt   = entry_dig(w_idx_inc, w_blank);
          w_seg_nxt   = entry_seg(w_idx_inc, r_data, w_dp);
          w_fd_nxt    = (r_idx == 3'd7);
        end else begin
          w_state_nxt = ST_DEAD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = 3'd0;
        w_cnt_nxt   = '0;
        w_dig_nxt   = 8'hFF;
        w_seg_nxt   = 8'hFF;
      end
    endcase
  end

  assign dig_en     = r_dig_en;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;

endmodule
